// File: rtl/input_conditioner.sv
// Synchronizes and debounces the switches and buttons, then latches button chords into an opcode on release.
// Latency 2 + DEBOUNCE_CYCLES cycles from raw edge to a/b/btn_level; there is no backpressure and outputs are always live.
module input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_WIDTH       = 20
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] sw_raw,
   input  logic [3:0]  btn_raw,
   output logic [7:0]  a,
   output logic [7:0]  b,
   output logic [3:0]  op_code,
   output logic [3:0]  btn_level,
   output logic [3:0]  btn_press,
   output logic        op_valid
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {IDLE, COLLECT} state_t;

   logic [19:0]          sync1;
   logic [19:0]          sync2;
   logic [15:0]          s_sw;
   logic [3:0]           s_btn;
   logic [15:0]          sw_prev;
   logic [CNT_WIDTH-1:0] sw_cnt;
   logic [CNT_WIDTH-1:0] sw_cnt_nxt;
   logic                 sw_load;
   logic [CNT_WIDTH-1:0] btn_cnt [4];
   state_t               state;
   state_t               state_nxt;
   logic [3:0]           chord;
   logic [3:0]           chord_nxt;
   logic [3:0]           op_code_nxt;
   logic                 op_valid_nxt;

   assign s_sw  = sync2[19:4];
   assign s_btn = sync2[3:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= {sw_raw, btn_raw};
         sync2 <= sync1;
      end
   end

   // Operands load on the same edge the stability count reaches its limit, so
   // a changed value appears 2 + DEBOUNCE_CYCLES cycles after the raw edge.
   always_comb begin
      sw_cnt_nxt = sw_cnt;
      if (s_sw != sw_prev) begin
         sw_cnt_nxt = '0;
      end else if (sw_cnt != CNT_MAX) begin
         sw_cnt_nxt = sw_cnt + 1'b1;
      end
   end

   assign sw_load = (s_sw == sw_prev) && (sw_cnt_nxt == CNT_MAX);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sw_prev <= '0;
         sw_cnt  <= '0;
         a       <= '0;
         b       <= '0;
      end else begin
         sw_prev <= s_sw;
         sw_cnt  <= sw_cnt_nxt;
         if (sw_load) begin
            a <= s_sw[15:8];
            b <= s_sw[7:0];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         btn_level <= '0;
         btn_press <= '0;
         for (int i = 0; i < 4; i++) begin
            btn_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            btn_press[i] <= 1'b0;
            if (s_btn[i] == btn_level[i]) begin
               btn_cnt[i] <= '0;
            end else if (btn_cnt[i] == CNT_MAX) begin
               btn_level[i] <= s_btn[i];
               btn_press[i] <= s_btn[i];
               btn_cnt[i]   <= '0;
            end else begin
               btn_cnt[i] <= btn_cnt[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         chord    <= '0;
         op_code  <= '0;
         op_valid <= 1'b0;
      end else begin
         state    <= state_nxt;
         chord    <= chord_nxt;
         op_code  <= op_code_nxt;
         op_valid <= op_valid_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      chord_nxt    = chord;
      op_code_nxt  = op_code;
      op_valid_nxt = 1'b0;
      case (state)
         IDLE: begin
            chord_nxt = '0;
            if (btn_level != '0) begin
               state_nxt = COLLECT;
               chord_nxt = btn_level;
            end
         end
         COLLECT: begin
            chord_nxt = chord | btn_level;
            // Commit only once every button of the chord has been released.
            if (btn_level == '0) begin
               op_code_nxt  = chord;
               op_valid_nxt = 1'b1;
               state_nxt    = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with a 4-cycle debounce window.
module tb_input_conditioner;

   logic        clk;
   logic        reset;
   logic [15:0] sw_raw;
   logic [3:0]  btn_raw;
   logic [7:0]  a;
   logic [7:0]  b;
   logic [3:0]  op_code;
   logic [3:0]  btn_level;
   logic [3:0]  btn_press;
   logic        op_valid;

   int errors;
   int checks;
   int vld_total;
   int press_total;
   int vld_base;
   int press_base;

   input_conditioner #(
      .DEBOUNCE_CYCLES(4),
      .CNT_WIDTH(3)
   ) dut (
      .clk(clk),
      .reset(reset),
      .sw_raw(sw_raw),
      .btn_raw(btn_raw),
      .a(a),
      .b(b),
      .op_code(op_code),
      .btn_level(btn_level),
      .btn_press(btn_press),
      .op_valid(op_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      vld_total   = 0;
      press_total = 0;
   end

   always @(negedge clk) begin
      if (op_valid) vld_total++;
      if (btn_press[0]) press_total++;
   end

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      errors  = 0;
      checks  = 0;
      reset   = 1'b1;
      sw_raw  = 16'h0000;
      btn_raw = 4'b0000;
      tick(3);
      check("rst_hold_ab", {a, b}, 16'h0000);
      check("rst_hold_op", {12'h0, op_code}, 16'h0000);
      reset = 1'b0;

      // Load arbitrary inputs, then hit reset mid-cycle
      sw_raw  = 16'h1234;
      btn_raw = 4'b1010;
      tick(10);
      check("pre_rst_ab", {a, b}, 16'h1234);
      check("pre_rst_lvl", {12'h0, btn_level}, 16'h000a);
      #2;
      reset = 1'b1;
      #1;
      check("async_rst_ab", {a, b}, 16'h0000);
      check("async_rst_lvl", {12'h0, btn_level}, 16'h0000);
      check("async_rst_op", {7'h0, op_valid, btn_press, op_code}, 16'h0000);
      tick(2);
      sw_raw  = 16'h0000;
      btn_raw = 4'b0000;
      tick(1);
      reset = 1'b0;
      tick(10);

      // Switch latency and glitch rejection
      sw_raw = 16'ha53c;
      tick(5);
      check("sw_early", {a, b}, 16'h0000);
      tick(1);
      check("sw_update", {a, b}, 16'ha53c);
      tick(10);
      sw_raw = 16'hffff;
      tick(3);
      sw_raw = 16'ha53c;
      tick(12);
      check("sw_glitch", {a, b}, 16'ha53c);

      // btnr bounce then held
      press_base = press_total;
      vld_base   = vld_total;
      btn_raw = 4'b0001; tick(1);
      btn_raw = 4'b0000; tick(1);
      btn_raw = 4'b0001; tick(1);
      btn_raw = 4'b0000; tick(1);
      btn_raw = 4'b0001;
      tick(5);
      check("bounce_lvl_early", {15'h0, btn_level[0]}, 16'h0000);
      tick(1);
      check("bounce_lvl", {15'h0, btn_level[0]}, 16'h0001);
      check("bounce_press", {15'h0, btn_press[0]}, 16'h0001);
      tick(1);
      check("bounce_press_end", {15'h0, btn_press[0]}, 16'h0000);
      tick(5);
      check("bounce_press_cnt", 16'(press_total - press_base), 16'd1);
      check("bounce_op_hold", {12'h0, op_code}, 16'h0000);
      check("bounce_no_vld", 16'(vld_total - vld_base), 16'd0);
      btn_raw = 4'b0000;
      tick(7);
      check("btnr_commit", {12'h0, op_code}, 16'h0001);
      check("btnr_vld", {15'h0, op_valid}, 16'h0001);
      tick(6);

      // Single press/release on btnd
      vld_base = vld_total;
      btn_raw = 4'b0010;
      tick(10);
      btn_raw = 4'b0000;
      tick(6);
      check("btnd_pre", {12'h0, op_code}, 16'h0001);
      tick(1);
      check("btnd_commit", {12'h0, op_code}, 16'h0002);
      tick(10);
      check("btnd_hold", {12'h0, op_code}, 16'h0002);
      check("btnd_vld_cnt", 16'(vld_total - vld_base), 16'd1);

      // Overlapping chord u then r
      vld_base = vld_total;
      btn_raw = 4'b1000; tick(10);
      btn_raw = 4'b1001; tick(10);
      btn_raw = 4'b0001; tick(10);
      btn_raw = 4'b0000;
      tick(6);
      check("chord_pre", {12'h0, op_code}, 16'h0002);
      check("chord_no_vld", 16'(vld_total - vld_base), 16'd0);
      tick(1);
      check("chord_commit", {12'h0, op_code}, 16'h0009);
      tick(10);
      check("chord_vld_cnt", 16'(vld_total - vld_base), 16'd1);

      // Reset while collecting btnl
      btn_raw = 4'b0100;
      tick(10);
      vld_base = vld_total;
      #3;
      reset = 1'b1;
      #1;
      check("mid_rst_op", {12'h0, op_code}, 16'h0000);
      check("mid_rst_lvl", {11'h0, op_valid, btn_level}, 16'h0000);
      tick(3);
      reset = 1'b0;
      check("mid_rst_no_vld", 16'(vld_total - vld_base), 16'd0);
      tick(5);
      check("mid_rst_lvl_early", {12'h0, btn_level}, 16'h0000);
      tick(1);
      check("mid_rst_relevel", {12'h0, btn_level}, 16'h0004);
      tick(10);
      btn_raw = 4'b0000;
      tick(7);
      check("mid_rst_commit", {12'h0, op_code}, 16'h0004);
      tick(5);
      check("mid_rst_vld_cnt", 16'(vld_total - vld_base), 16'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
